lcd_bus_arbiter: RTL and testbench

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

---
 rtl/lcd_bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
//
// Shares one HD44780-style LCD write bus between two byte producers. Each
// accepted byte is driven through a setup / enable-pulse / hold sequence,
// followed by a busy wait. The wait is longer for clear and home commands.
// Arbitration runs only while idle:
//   - A locked owner keeps the bus.
//   - Otherwise a single valid requester wins.
//   - Otherwise ties alternate round-robin.
//
// Parameters (all counts are in clk2 cycles):
//   T_SU        : rs/db stable time before lcd_e rises
//   T_EN        : lcd_e high time
//   T_HOLD      : rs/db hold time after lcd_e falls
//   T_WAIT      : busy wait after an ordinary byte
//   T_WAIT_LONG : busy wait after clear/home commands
//
// Ports:
//   clk2, rst                  : rising-edge clock, synchronous active-high reset
//   reqN_valid/rs/data/lock    : requester N byte, register select, bus lock
//   reqN_ready                 : one-cycle pulse when requester N's byte is taken
//   grant[1:0]                 : one-hot current owner, 00 = none
//   lcd_rs, lcd_e, lcd_db[7:0] : LCD bus
//   busy                       : high whenever a transfer or its wait is running
module lcd_bus_arbiter #(
  parameter int T_SU        = 2,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_WAIT      = 40,
  parameter int T_WAIT_LONG = 1640
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic [1:0] grant,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD,
    S_WAIT
  } state_t;

  localparam logic [10:0] SU_LOAD   = 11'(T_SU - 1);
  localparam logic [10:0] EN_LOAD   = 11'(T_EN - 1);
  localparam logic [10:0] HOLD_LOAD = 11'(T_HOLD - 1);
  localparam logic [10:0] WAIT_LOAD = 11'(T_WAIT - 1);
  localparam logic [10:0] LONG_LOAD = 11'(T_WAIT_LONG - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_db_q, lcd_db_d;

  logic [1:0]  sel;
  logic [1:0]  accept;
  logic        owner_locked;
  logic        is_long;
  logic        drive_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    rs_d     = rs_q;
    data_d   = data_q;
    sel      = 2'b00;
    accept   = 2'b00;

    owner_locked = (grant_q[0] & req0_lock) | (grant_q[1] & req1_lock);
    // Clear display (01) and return home (02/03) need the long wait.
    is_long = ~rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    unique case (state_q)
      S_IDLE: begin
        // A locked owner keeps the bus even with no byte pending.
        // last_q = 1 means requester 1 was served last, so 0 wins a tie.
        if (owner_locked) begin
          sel = grant_q;
        end else if (req0_valid && req1_valid) begin
          sel = last_q ? 2'b01 : 2'b10;
        end else if (req0_valid) begin
          sel = 2'b01;
        end else if (req1_valid) begin
          sel = 2'b10;
        end
        grant_d = sel;
        accept  = sel & {req1_valid, req0_valid};
        if (accept[0]) begin
          rs_d   = req0_rs;
          data_d = req0_data;
        end else if (accept[1]) begin
          rs_d   = req1_rs;
          data_d = req1_data;
        end
        if (accept != 2'b00) begin
          last_d  = accept[1];
          cnt_d   = SU_LOAD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 11'd0) begin
          state_d = S_ENABLE;
          cnt_d   = EN_LOAD;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      S_ENABLE: begin
        if (cnt_q == 11'd0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 11'd0) begin
          state_d = S_WAIT;
          cnt_d   = is_long ? LONG_LOAD : WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 11'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 11'd0;
      end
    endcase

    // The LCD pins come from flops fed by the next state. This keeps them
    // glitch-free and still aligned with the state they belong to.
    drive_d  = (state_d == S_SETUP) || (state_d == S_ENABLE) || (state_d == S_HOLD);
    lcd_e_d  = (state_d == S_ENABLE);
    lcd_rs_d = drive_d & rs_d;
    lcd_db_d = drive_d ? data_d : 8'h00;
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 11'd0;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_db_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      lcd_e_q  <= lcd_e_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_db_q <= lcd_db_d;
    end
  end

  // Ready is suppressed while reset is high: a byte taken then would be lost.
  assign req0_ready = accept[0] & ~rst;
  assign req1_ready = accept[1] & ~rst;
  assign grant      = grant_q;
  assign lcd_e      = lcd_e_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_db     = lcd_db_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter
//
// Directed bench for lcd_bus_arbiter, using the default timing parameters.
// A reference model tracks, for each transfer, the cycles elapsed since
// acceptance. It derives the expected bus and handshake values from that
// elapsed count. Directed scenarios add hand-computed literal checks.
module tb_lcd_bus_arbiter;

  localparam int T_SU        = 2;
  localparam int T_EN        = 12;
  localparam int T_HOLD      = 2;
  localparam int T_WAIT      = 40;
  localparam int T_WAIT_LONG = 1640;

  logic       clk2 = 1'b0;
  logic       rst;
  logic       req0_valid, req0_rs, req0_lock, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_lock, req1_ready;
  logic [7:0] req1_data;
  logic [1:0] grant;
  logic       lcd_rs, lcd_e, busy;
  logic [7:0] lcd_db;

  int checks = 0;
  int errors = 0;

  lcd_bus_arbiter #(
    .T_SU(T_SU), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_WAIT(T_WAIT), .T_WAIT_LONG(T_WAIT_LONG)
  ) dut (
    .clk2(clk2), .rst(rst),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
    .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
    .req1_lock(req1_lock), .req1_ready(req1_ready),
    .grant(grant), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_db(lcd_db), .busy(busy)
  );

  always #5 clk2 = ~clk2;

  // Model state: m_phase is -1 when idle, else cycles since acceptance.
  int         m_phase = -1;
  int         m_total = 0;
  logic [1:0] m_owner = 2'b00;
  logic       m_last  = 1'b1;
  logic       m_rs    = 1'b0;
  logic [7:0] m_data  = 8'h00;
  bit         model_on = 1'b0;

  function automatic logic [1:0] model_sel();
    logic owner_lock;
    owner_lock = (m_owner == 2'b01 && req0_lock) || (m_owner == 2'b10 && req1_lock);
    if (owner_lock) return m_owner;
    if (req0_valid && req1_valid) return m_last ? 2'b01 : 2'b10;
    if (req0_valid) return 2'b01;
    if (req1_valid) return 2'b10;
    return 2'b00;
  endfunction

  // Advance the model on each rising edge using the inputs sampled there.
  always @(posedge clk2) begin : model_step
    logic [1:0] s;
    logic [1:0] acc;
    logic       long_cmd;
    model_on = 1'b1;
    if (rst) begin
      m_phase = -1;
      m_owner = 2'b00;
      m_last  = 1'b1;
    end else if (m_phase < 0) begin
      s       = model_sel();
      m_owner = s;
      acc     = s & {req1_valid, req0_valid};
      if (acc != 2'b00) begin
        m_rs     = acc[0] ? req0_rs : req1_rs;
        m_data   = acc[0] ? req0_data : req1_data;
        m_last   = acc[1];
        long_cmd = !m_rs && (m_data >= 8'h01 && m_data <= 8'h03);
        m_total  = T_SU + T_EN + T_HOLD + (long_cmd ? T_WAIT_LONG : T_WAIT);
        m_phase  = 0;
      end
    end else begin
      m_phase++;
      if (m_phase == m_total) m_phase = -1;
    end
  end

  task automatic compareLoop();
    logic [1:0] exp_ready, exp_grant, s;
    logic       exp_busy, exp_e, exp_rs, drive;
    logic [7:0] exp_db;
    forever begin
      @(negedge clk2);
      if (model_on) begin
        exp_grant = m_owner;
        if (m_phase < 0) begin
          s         = model_sel();
          exp_ready = rst ? 2'b00 : (s & {req1_valid, req0_valid});
          exp_busy  = 1'b0;
          exp_e     = 1'b0;
          exp_rs    = 1'b0;
          exp_db    = 8'h00;
        end else begin
          exp_ready = 2'b00;
          exp_busy  = 1'b1;
          exp_e     = (m_phase >= T_SU) && (m_phase < T_SU + T_EN);
          drive     = (m_phase < T_SU + T_EN + T_HOLD);
          exp_rs    = drive ? m_rs : 1'b0;
          exp_db    = drive ? m_data : 8'h00;
        end
        checks++;
        if ({req1_ready, req0_ready, grant, busy, lcd_e, lcd_rs, lcd_db} !==
            {exp_ready, exp_grant, exp_busy, exp_e, exp_rs, exp_db}) begin
          errors++;
          $display("[TB] FAIL model_cycle t=%0t: ready=%b grant=%b busy=%b e=%b rs=%b db=%h, expected ready=%b grant=%b busy=%b e=%b rs=%b db=%h",
                   $time, {req1_ready, req0_ready}, grant, busy, lcd_e, lcd_rs, lcd_db,
                   exp_ready, exp_grant, exp_busy, exp_e, exp_rs, exp_db);
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int n, input logic v, input logic rs_in,
                               input logic [7:0] d, input logic lk);
    if (n == 0) begin
      req0_valid = v; req0_rs = rs_in; req0_data = d; req0_lock = lk;
    end else begin
      req1_valid = v; req1_rs = rs_in; req1_data = d; req1_lock = lk;
    end
  endtask

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic doReset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic waitAccept(output int who);
    who = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk2);
      if (req0_ready || req1_ready) begin
        who = req0_ready ? 0 : 1;
        return;
      end
    end
    checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk2);
      if (!busy) return;
    end
    checkOutput("idle_timeout", 0, 1);
  endtask

  // Called right after the post-accept input update; first negedge is cycle 1.
  task automatic measureTransfer(input string name, input logic [7:0] exp_db, input int exp_busy);
    int busy_cnt = 0;
    int e_cnt = 0;
    int e_first = -1;
    int db_bad = 0;
    bit done = 1'b0;
    for (int k = 1; k <= 3000 && !done; k++) begin
      @(negedge clk2);
      if (busy) begin
        busy_cnt++;
        if (lcd_e) begin
          e_cnt++;
          if (e_first < 0) e_first = k;
        end
        if (k <= T_SU + T_EN + T_HOLD && lcd_db !== exp_db) db_bad++;
      end else begin
        done = 1'b1;
      end
    end
    checkOutput({name, "_busy_cycles"}, busy_cnt, exp_busy);
    checkOutput({name, "_e_cycles"}, e_cnt, 12);
    checkOutput({name, "_e_first"}, e_first, 3);
    checkOutput({name, "_db_bad"}, db_bad, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int who;
    int lock_exp [5] = '{1, 1, 1, 1, 0};
    fork
      compareLoop();
    join_none

    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk2);
    @(negedge clk2);
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_lcd_e", lcd_e, 0);
    checkOutput("reset_ready", {req1_ready, req0_ready}, 0);
    step();
    rst = 1'b0;

    $display("[TB] single byte with data change after accept");
    applyStimulus(0, 1'b1, 1'b1, 8'h41, 1'b0);
    waitAccept(who);
    checkOutput("single_owner", who, 0);
    step();
    applyStimulus(0, 1'b0, 1'b1, 8'h42, 1'b0);
    measureTransfer("single", 8'h41, 56);

    $display("[TB] long command versus character 01");
    step();
    applyStimulus(0, 1'b1, 1'b0, 8'h01, 1'b0);
    waitAccept(who);
    step();
    applyStimulus(0, 1'b0, 1'b0, 8'h01, 1'b0);
    measureTransfer("long_cmd", 8'h01, 1656);
    step();
    applyStimulus(0, 1'b1, 1'b1, 8'h01, 1'b0);
    waitAccept(who);
    step();
    applyStimulus(0, 1'b0, 1'b1, 8'h01, 1'b0);
    measureTransfer("long_char", 8'h01, 56);

    $display("[TB] tie from reset");
    step();
    rst = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 8'h10, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 8'h20, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waitAccept(who);
      checkOutput($sformatf("tie_order_%0d", i), who, i % 2);
    end
    step();
    applyStimulus(0, 1'b0, 1'b1, 8'h10, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 8'h20, 1'b0);
    waitIdle();

    $display("[TB] locked burst from requester 1");
    doReset();
    applyStimulus(1, 1'b1, 1'b1, 8'h50, 1'b1);
    for (int a = 0; a < 5; a++) begin
      waitAccept(who);
      checkOutput($sformatf("lock_order_%0d", a), who, lock_exp[a]);
      step();
      if (a == 0) applyStimulus(0, 1'b1, 1'b1, 8'h30, 1'b0);
      if (a < 3) applyStimulus(1, 1'b1, 1'b1, 8'h51 + 8'(a), 1'b1);
      else if (a == 3) applyStimulus(1, 1'b0, 1'b1, 8'h53, 1'b0);
      else applyStimulus(0, 1'b0, 1'b1, 8'h30, 1'b0);
    end
    waitIdle();

    $display("[TB] lock release with no pending byte");
    step();
    applyStimulus(0, 1'b1, 1'b1, 8'h33, 1'b1);
    waitAccept(who);
    checkOutput("lockrel_owner", who, 0);
    step();
    applyStimulus(0, 1'b0, 1'b1, 8'h33, 1'b1);
    waitIdle();
    @(negedge clk2);
    checkOutput("lock_hold_grant", grant, 1);
    step();
    applyStimulus(0, 1'b0, 1'b1, 8'h33, 1'b0);
    @(negedge clk2);
    checkOutput("lock_release_same_cycle", grant, 1);
    @(negedge clk2);
    checkOutput("lock_release_next", grant, 0);

    $display("[TB] reset in the middle of the enable pulse");
    step();
    applyStimulus(0, 1'b1, 1'b1, 8'h5A, 1'b0);
    waitAccept(who);
    step();
    applyStimulus(0, 1'b0, 1'b1, 8'h5A, 1'b0);
    begin : wait_e
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk2);
        seen = lcd_e;
      end
      checkOutput("rst_mid_e_seen", seen, 1);
    end
    repeat (4) step();
    rst = 1'b1;
    @(negedge clk2);
    checkOutput("rst_mid_e_before", lcd_e, 1);
    step();
    rst = 1'b0;
    @(negedge clk2);
    checkOutput("rst_mid_e_lcd_e", lcd_e, 0);
    checkOutput("rst_mid_e_busy", busy, 0);
    checkOutput("rst_mid_e_grant", grant, 0);
    step();
    applyStimulus(1, 1'b1, 1'b1, 8'h66, 1'b0);
    waitAccept(who);
    checkOutput("after_reset_owner", who, 1);
    step();
    applyStimulus(1, 1'b0, 1'b1, 8'h66, 1'b0);
    measureTransfer("after_reset", 8'h66, 56);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
